// File: rtl/filt_bram_loader.sv
// -----------------------------------------------------------------------------
// filt_bram_loader
//
// Front end of the disparity filtering stage. Packs the raster-order pixel
// stream from block matching into one of two ping-pong frame banks in the
// filter BRAM (row-major), then hands each complete bank to the filter through
// the start/index/idle handshake. The input stream cannot stall, so any frame
// that arrives while no bank is free is dropped and flagged.
//
// Optional build macro:
//   FILT_LOADER_STATS_EN  - when defined, dropped_count counts frame_dropped
//                           and short_frame pulses (saturating). When
//                           undefined, dropped_count is tied to zero.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid, in_sof  pixel qualifier, first pixel of frame
//   in_disparity      disparity (DISP_BITS)
//   in_confidence     confidence (8)
//   in_gray           gray level (8)
//   wr_addr/index     BRAM write address and bank select
//   wr_data           {disparity, confidence, gray}
//   wr_ena            BRAM write enable, one per accepted pixel
//   filt_start        one-cycle pulse: bank filt_index ready for filtering
//   filt_index        bank handed to the filter, stable until next filt_start
//   filt_idle         filter may accept a start
//   frame_dropped     one-cycle pulse: incoming frame discarded (filter busy)
//   short_frame       one-cycle pulse: SOF arrived before frame completion
//   dropped_count     saturating count of drop/short events
// -----------------------------------------------------------------------------
// state        | meaning
// WAIT_SOF     | ignore pixels until a valid SOF starts a frame
// LOAD         | writing pixels of the current frame into the current bank
// HANDOFF      | bank full, waiting for filter idle to issue filt_start
// -----------------------------------------------------------------------------
module filt_bram_loader #(
    parameter int WIDTH      = 120,
    parameter int HEIGHT     = 240,
    parameter int FRAME_SIZE = WIDTH * HEIGHT,
    parameter int ADDR_W     = $clog2(FRAME_SIZE),
    parameter int DISP_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [DISP_BITS-1:0]  in_disparity,
    input  logic [7:0]            in_confidence,
    input  logic [7:0]            in_gray,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  wr_index,
    output logic [DISP_BITS+15:0] wr_data,
    output logic                  wr_ena,
    output logic                  filt_start,
    output logic                  filt_index,
    input  logic                  filt_idle,
    output logic                  frame_dropped,
    output logic                  short_frame,
    output logic [15:0]           dropped_count
);

    localparam logic [1:0] ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] ST_LOAD     = 2'd1;
    localparam logic [1:0] ST_HANDOFF  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_SIZE - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

    // Input register stage: the FSM works on the registered pixel.
    logic                  in_valid_q;
    logic                  in_sof_q;
    logic [DISP_BITS+15:0] in_pix_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_valid_q <= 1'b0;
            in_sof_q   <= 1'b0;
            in_pix_q   <= '0;
        end else begin
            in_valid_q <= in_valid;
            in_sof_q   <= in_sof;
            in_pix_q   <= {in_disparity, in_confidence, in_gray};
        end
    end

    logic [1:0]            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;       // address of the next pixel
    logic                  bank_q, bank_d;
    logic [1:0]            holdoff_q, holdoff_d; // filt_idle ignore window
    logic                  wr_ena_q, wr_ena_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic                  wr_index_q, wr_index_d;
    logic [DISP_BITS+15:0] wr_data_q, wr_data_d;
    logic                  filt_start_q, filt_start_d;
    logic                  filt_index_q, filt_index_d;
    logic                  frame_dropped_q, frame_dropped_d;
    logic                  short_frame_q, short_frame_d;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        bank_d          = bank_q;
        holdoff_d       = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : 2'd0;
        wr_ena_d        = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_index_d      = wr_index_q;
        wr_data_d       = wr_data_q;
        filt_start_d    = 1'b0;
        filt_index_d    = filt_index_q;
        frame_dropped_d = 1'b0;
        short_frame_d   = 1'b0;

        case (state_q)
            ST_WAIT_SOF: begin
                if (in_valid_q && in_sof_q) begin
                    wr_ena_d   = 1'b1;
                    wr_addr_d  = '0;
                    wr_index_d = bank_q;
                    wr_data_d  = in_pix_q;
                    addr_d     = ONE_ADDR;
                    state_d    = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (in_valid_q) begin
                    wr_ena_d   = 1'b1;
                    wr_index_d = bank_q;
                    wr_data_d  = in_pix_q;
                    if (in_sof_q) begin
                        // Early SOF: discard the partial frame and restart
                        // this bank with the new frame's first pixel.
                        short_frame_d = 1'b1;
                        wr_addr_d     = '0;
                        addr_d        = ONE_ADDR;
                    end else begin
                        wr_addr_d = addr_q;
                        if (addr_q == LAST_ADDR) begin
                            addr_d  = '0;
                            state_d = ST_HANDOFF;
                        end else begin
                            addr_d = addr_q + ONE_ADDR;
                        end
                    end
                end
            end

            ST_HANDOFF: begin
                // A new frame starting now has nowhere to go; its SOF flags
                // the drop and the rest of it is ignored in WAIT_SOF.
                if (in_valid_q && in_sof_q) begin
                    frame_dropped_d = 1'b1;
                end
                if (filt_idle && (holdoff_q == 2'd0)) begin
                    filt_start_d = 1'b1;
                    filt_index_d = bank_q;
                    bank_d       = ~bank_q;
                    holdoff_d    = 2'd2;
                    state_d      = ST_WAIT_SOF;
                end
            end

            default: begin
                state_d = ST_WAIT_SOF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_WAIT_SOF;
            addr_q          <= '0;
            bank_q          <= 1'b0;
            holdoff_q       <= 2'd0;
            wr_ena_q        <= 1'b0;
            wr_addr_q       <= '0;
            wr_index_q      <= 1'b0;
            wr_data_q       <= '0;
            filt_start_q    <= 1'b0;
            filt_index_q    <= 1'b1;
            frame_dropped_q <= 1'b0;
            short_frame_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            bank_q          <= bank_d;
            holdoff_q       <= holdoff_d;
            wr_ena_q        <= wr_ena_d;
            wr_addr_q       <= wr_addr_d;
            wr_index_q      <= wr_index_d;
            wr_data_q       <= wr_data_d;
            filt_start_q    <= filt_start_d;
            filt_index_q    <= filt_index_d;
            frame_dropped_q <= frame_dropped_d;
            short_frame_q   <= short_frame_d;
        end
    end

    assign wr_ena        = wr_ena_q;
    assign wr_addr       = wr_addr_q;
    assign wr_index      = wr_index_q;
    assign wr_data       = wr_data_q;
    assign filt_start    = filt_start_q;
    assign filt_index    = filt_index_q;
    assign frame_dropped = frame_dropped_q;
    assign short_frame   = short_frame_q;

`ifdef FILT_LOADER_STATS_EN
    // Counts on the same edge that raises the pulse, so the count and the
    // pulse become visible together.
    logic [15:0] dropped_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_count_q <= 16'h0000;
        end else if ((frame_dropped_d || short_frame_d) &&
                     (dropped_count_q != 16'hFFFF)) begin
            dropped_count_q <= dropped_count_q + 16'h0001;
        end
    end

    assign dropped_count = dropped_count_q;
`else
    assign dropped_count = 16'h0000;
`endif

endmodule

// File: tb/tb_filt_bram_loader.sv
module tb_filt_bram_loader;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FS = W * H;
    localparam int AW = $clog2(FS);
    localparam int DB = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_sof;
    logic [DB-1:0]     in_disparity;
    logic [7:0]        in_confidence;
    logic [7:0]        in_gray;
    logic [AW-1:0]     wr_addr;
    logic              wr_index;
    logic [DB+15:0]    wr_data;
    logic              wr_ena;
    logic              filt_start;
    logic              filt_index;
    logic              filt_idle;
    logic              frame_dropped;
    logic              short_frame;
    logic [15:0]       dropped_count;

    always #5 clk = ~clk;

    filt_bram_loader #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .DISP_BITS (DB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_sof        (in_sof),
        .in_disparity  (in_disparity),
        .in_confidence (in_confidence),
        .in_gray       (in_gray),
        .wr_addr       (wr_addr),
        .wr_index      (wr_index),
        .wr_data       (wr_data),
        .wr_ena        (wr_ena),
        .filt_start    (filt_start),
        .filt_index    (filt_index),
        .filt_idle     (filt_idle),
        .frame_dropped (frame_dropped),
        .short_frame   (short_frame),
        .dropped_count (dropped_count)
    );

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Expected BRAM writes and handshake events, each stamped with the clock
    // edge after which it must be visible.
    typedef struct {
        int             stamp;
        int             addr;
        int             idx;
        logic [DB+15:0] data;
    } wr_t;

    // event codes: 0 short_frame, 1 frame_dropped, 2 start bank0, 3 start bank1
    typedef struct {
        int stamp;
        int code;
    } ev_t;

    wr_t wq[$];
    ev_t eq[$];
    bit  rst_at[int];

    // Reference model: frame-level bookkeeping of the two banks.
    bit             m_loading;
    bit             m_full;
    int             m_count;
    int             m_bank;
    int             m_last_start;
    int             m_drops;
    bit             p_valid;
    bit             p_sof;
    logic [DB+15:0] p_data;
    bit             idle_r;

    function automatic void model_reset();
        m_loading    = 1'b0;
        m_full       = 1'b0;
        m_count      = 0;
        m_bank       = 0;
        m_last_start = -100;
        m_drops      = 0;
    endfunction

    function automatic void push_wr(int stamp, int addr);
        wr_t w;
        w.stamp = stamp;
        w.addr  = addr;
        w.idx   = m_bank;
        w.data  = p_data;
        wq.push_back(w);
    endfunction

    function automatic void push_ev(int stamp, int code);
        ev_t e;
        e.stamp = stamp;
        e.code  = code;
        eq.push_back(e);
    endfunction

    function automatic void bump_drops();
        if (m_drops < 65535) m_drops++;
    endfunction

    // Processes the pixel presented one edge earlier, with the filt_idle
    // value present at edge 'stamp'.
    function automatic void model_step(int stamp, bit idle);
        bit sof_pix;
        sof_pix = p_valid && p_sof;
        if (m_full) begin
            if (sof_pix) begin
                push_ev(stamp, 1);
                bump_drops();
            end
            if (idle && stamp >= m_last_start + 3) begin
                push_ev(stamp, 2 + m_bank);
                m_bank       = 1 - m_bank;
                m_full       = 1'b0;
                m_last_start = stamp;
            end
        end else if (m_loading) begin
            if (p_valid) begin
                if (p_sof) begin
                    push_ev(stamp, 0);
                    bump_drops();
                    push_wr(stamp, 0);
                    m_count = 1;
                end else begin
                    push_wr(stamp, m_count);
                    m_count++;
                    if (m_count == FS) begin
                        m_full    = 1'b1;
                        m_loading = 1'b0;
                    end
                end
            end
        end else if (sof_pix) begin
            push_wr(stamp, 0);
            m_count   = 1;
            m_loading = 1'b1;
        end
    endfunction

    task automatic drive(bit rst, bit v, bit s, bit idle);
        @(negedge clk);
        reset         = rst;
        in_valid      = v;
        in_sof        = s;
        filt_idle     = idle;
        in_disparity  = DB'($urandom);
        in_confidence = 8'($urandom);
        in_gray       = 8'($urandom);
        if (rst) begin
            rst_at[edge_n + 1] = 1'b1;
            model_reset();
            p_valid = 1'b0;
            p_sof   = 1'b0;
        end else begin
            model_step(edge_n + 1, idle);
            p_valid = v;
            p_sof   = s;
            p_data  = {in_disparity, in_confidence, in_gray};
        end
    endtask

    task automatic frame(int n, bit idle);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, (i == 0), idle);
    endtask

    task automatic gap(int n, bit idle);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, idle);
    endtask

    function automatic void check_ev(int code);
        ev_t e;
        checks++;
        if (eq.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected: edge %0d got code %0d, none expected", edge_n, code);
        end else begin
            e = eq.pop_front();
            if (e.stamp != edge_n || e.code != code) begin
                errors++;
                $display("FAIL event: got code %0d at edge %0d, expected code %0d at edge %0d",
                         code, edge_n, e.code, e.stamp);
            end
        end
    endfunction

    int exp_dc;

    function automatic int expected_dc();
`ifdef FILT_LOADER_STATS_EN
        return m_drops;
`else
        return 0;
`endif
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        wr_t w;
        if (rst_at.exists(edge_n)) begin
            checks++;
            if (wr_ena !== 1'b0 || wr_addr !== '0 || wr_index !== 1'b0 || wr_data !== '0 ||
                filt_start !== 1'b0 || filt_index !== 1'b1 || frame_dropped !== 1'b0 ||
                short_frame !== 1'b0 || dropped_count !== 16'h0) begin
                errors++;
                $display("FAIL reset_values: edge %0d got ena=%b addr=%0d idx=%b data=%h start=%b findex=%b drop=%b short=%b cnt=%0d, expected all 0 except filt_index=1",
                         edge_n, wr_ena, wr_addr, wr_index, wr_data, filt_start, filt_index,
                         frame_dropped, short_frame, dropped_count);
            end
        end
        if (wr_ena === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: edge %0d addr %0d bank %b", edge_n, wr_addr, wr_index);
            end else begin
                w = wq.pop_front();
                if (w.stamp != edge_n || w.addr != int'(wr_addr) ||
                    w.idx != int'(wr_index) || w.data !== wr_data) begin
                    errors++;
                    $display("FAIL write: got edge %0d addr %0d bank %0d data %h, expected edge %0d addr %0d bank %0d data %h",
                             edge_n, wr_addr, wr_index, wr_data, w.stamp, w.addr, w.idx, w.data);
                end
            end
        end
        while (wq.size() > 0 && wq[0].stamp <= edge_n) begin
            checks++;
            errors++;
            $display("FAIL write_missing: at edge %0d no write, expected addr %0d bank %0d",
                     wq[0].stamp, wq[0].addr, wq[0].idx);
            w = wq.pop_front();
        end
        if (short_frame === 1'b1)   check_ev(0);
        if (frame_dropped === 1'b1) check_ev(1);
        if (filt_start === 1'b1)    check_ev(2 + int'(filt_index));
        while (eq.size() > 0 && eq[0].stamp <= edge_n) begin
            checks++;
            errors++;
            $display("FAIL event_missing: at edge %0d nothing seen, expected code %0d",
                     eq[0].stamp, eq[0].code);
            void'(eq.pop_front());
        end
    end

    task automatic check_count(string name);
        @(negedge clk);
        exp_dc = expected_dc();
        checks++;
        if (int'(dropped_count) != exp_dc) begin
            errors++;
            $display("FAIL %s: dropped_count got %0d expected %0d", name, dropped_count, exp_dc);
        end
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_sof        = 1'b0;
        filt_idle     = 1'b1;
        in_disparity  = '0;
        in_confidence = '0;
        in_gray       = '0;
        p_valid       = 1'b0;
        p_sof         = 1'b0;
        p_data        = '0;
        idle_r        = 1'b1;
        model_reset();

        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1);

        // Pixels with no SOF after reset: nothing written, no start.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b1);
        gap(2, 1'b1);

        // Single frame with filter idle: bank 0, start 2 edges after pixel 7.
        frame(FS, 1'b1);
        gap(3, 1'b1);

        // Next frame to bank 1 with the filter busy, then three SOFs dropped.
        frame(FS, 1'b0);
        gap(2, 1'b0);
        frame(4, 1'b0);
        frame(4, 1'b0);
        frame(FS, 1'b0);
        gap(3, 1'b1);

        // Short frame: SOF at pixel 5, then a full frame.
        frame(5, 1'b1);
        frame(FS, 1'b1);
        gap(4, 1'b1);
        check_count("count_directed");

        // Reset at pixel 3, then a full frame lands in bank 0.
        frame(3, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        frame(FS, 1'b1);
        gap(4, 1'b1);

        // Reset while waiting in handoff: no start for that bank.
        frame(FS, 1'b0);
        gap(2, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        gap(4, 1'b1);

        // Randomised traffic with bursty filter availability.
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % 48) == 0) idle_r = !idle_r;
            drive((($urandom % 1500) == 0), (($urandom % 4) != 0),
                  (($urandom % 10) == 0), idle_r);
        end

        gap(12, 1'b1);
        check_count("count_final");

        checks++;
        if (wq.size() != 0 || eq.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: writes left %0d events left %0d, expected 0 and 0",
                     wq.size(), eq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filt_bram_loader.md
Name: filt_bram_loader

Overview:
- Front end of the disparity filtering stage.
- Accepts the raster-order pixel stream from block matching (disparity, confidence, gray) and packs it into the filter frame BRAM, row-major.
- Uses two ping-pong banks. When a bank holds a complete frame, hands it to the filter reader/writer through the start/index/idle handshake, then fills the other bank.
- The input stream cannot stall, so pixels are dropped and flagged whenever no bank is free.

Parameters:
- width, 120, pixels per line
- height, 240, lines per frame
- frame_size, width*height, pixels per frame
- addr_w, $clog2(frame_size), BRAM address width
- disp_bits, 5, disparity width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  pixel qualifier
- in_sof  in  1  first pixel of frame; meaningful only with in_valid
- in_disparity  in  disp_bits  disparity
- in_confidence  in  8  confidence
- in_gray  in  8  gray level
- wr_addr  out  addr_w  BRAM write address
- wr_index  out  1  BRAM bank select
- wr_data  out  disp_bits+16  packed {disparity, confidence, gray}: [disp_bits+15:16], [15:8], [7:0]
- wr_ena  out  1  BRAM write enable
- filt_start  out  1  one-cycle pulse: bank filt_index is ready for filtering
- filt_index  out  1  bank handed to filter; held stable until the next filt_start
- filt_idle  in  1  filter idle (high = may accept start)
- frame_dropped  out  1  one-cycle pulse, frame discarded
- short_frame  out  1  one-cycle pulse, SOF before frame completion
- dropped_count  out  16  saturating dropped-frame count (see Optional Feature)

Behaviour:
- Reset: synchronous, active-high; clock clk.
- Reset values:
  - wr_ena=0, wr_addr=0, wr_index=0, wr_data=0
  - filt_start=0, filt_index=1
  - frame_dropped=0, short_frame=0, dropped_count=0
  - internal write bank=0, state=WAIT_SOF
- State machine:
  - WAIT_SOF: ignore pixels until in_valid&in_sof. That pixel is written to address 0 of the current bank; go to LOAD.
  - LOAD: each in_valid pixel is written at an address incremented by 1 per pixel (row-major, no gaps). When pixel frame_size-1 is written, go to HANDOFF.
  - HANDOFF: waits for filt_idle=1. Then assert filt_start for one cycle with filt_index=current bank, toggle the write bank, go to WAIT_SOF.
    - filt_start is asserted no earlier than the cycle after the final wr_ena.
    - filt_start is never high on two consecutive cycles.
    - filt_idle is ignored for 2 cycles after filt_start.
- Write latency: inputs are registered. The wr_* outputs appear exactly 1 cycle after the accepting in_valid edge. wr_ena is high exactly once per accepted pixel.
- Boundary conditions:
  - in_sof in LOAD before frame completion: pulse short_frame. That pixel restarts at address 0 of the same bank; the partial frame is discarded, no handoff.
  - in_valid&in_sof in HANDOFF (filter still busy): the whole incoming frame is dropped.
    - No writes occur.
    - frame_dropped pulses once.
    - Stay in HANDOFF.
    - After handoff, resume at WAIT_SOF; the remainder of the dropped frame is ignored.
  - Pixels in HANDOFF without in_sof are discarded silently.
  - filt_idle already high when the last pixel is written: filt_start follows on the next cycle, i.e. 2 cycles after the final accepting edge.
  - Reset mid-frame or mid-handoff: all state returns to reset values; no filt_start is issued for the partial frame.
  - Address counter never exceeds frame_size-1. Wrap occurs only via state change.

Optional Feature:
- Macro FILT_LOADER_STATS_EN.
- Defined: dropped_count increments, saturating at 16'hFFFF, on each frame_dropped or short_frame pulse. Cleared only by reset.
- Undefined: dropped_count is tied to 0 and no counter logic is built. All other behaviour is identical.

Test Plan:
- width=4, height=2, filt_idle=1: one 8-pixel frame with SOF -> wr_addr 0..7 on bank 0 with correct packing; filt_start pulses 2 cycles after pixel 7 with filt_index=0; the next frame writes bank 1.
- Two back-to-back frames with filt_idle held 0 after the first start -> second frame written to bank 1 and waits in HANDOFF. A third SOF gives frame_dropped=1 and zero wr_ena. Raising filt_idle gives filt_start with filt_index=1.
- SOF at pixel 5 of a frame -> short_frame pulse; that pixel is written to addr 0; no filt_start until 8 further pixels complete.
- Pixels without a prior SOF after reset -> no wr_ena, no start.
- Reset asserted at pixel 3 -> all outputs at reset values next cycle; a following full frame lands in bank 0.
- FILT_LOADER_STATS_EN defined, 3 drops plus 1 short frame -> dropped_count=4. Undefined -> dropped_count=0.
